// File: rtl/mem_dma.sv
// mem_dma: single-channel memory initiator for a synchronous single-port RAM.
//
// Copy mode moves `len` 32-bit words from src to dst, two cycles per word
// (read, then write with the returned data). Fill mode writes a latched
// pattern over `len` words, one word per cycle.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   start, mode       command strobe (idle only); 0 = copy, 1 = fill
//   src_addr,dst_addr byte addresses, low two bits ignored
//   len, pattern      word count and fill word, sampled with start
//   abort             early termination request
//   busy, done        in-progress flag, one-cycle completion pulse
//   aborted           last transfer was aborted (held until next start)
//   words_done        words written in the current or last transfer
//   req/addr/we/be/wdata  RAM request; rdata returns one cycle after a read
module mem_dma #(
  parameter int unsigned LEN_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 mode,
  input  logic [31:0]          src_addr,
  input  logic [31:0]          dst_addr,
  input  logic [LEN_WIDTH-1:0] len,
  input  logic [31:0]          pattern,
  input  logic                 abort,
  output logic                 busy,
  output logic                 done,
  output logic                 aborted,
  output logic [LEN_WIDTH-1:0] words_done,
  output logic                 req,
  output logic [31:0]          addr,
  output logic                 we,
  output logic [3:0]           be,
  output logic [31:0]          wdata,
  input  logic [31:0]          rdata
);

  typedef enum logic [2:0] {StIdle, StRd, StWr, StFill, StFin} state_e;

  state_e               state_q, state_d;
  logic [31:0]          src_q, src_d;
  logic [31:0]          dst_q, dst_d;
  logic [31:0]          pattern_q, pattern_d;
  logic [LEN_WIDTH-1:0] len_q, len_d;
  logic [LEN_WIDTH-1:0] words_q, words_d;
  logic                 aborted_q, aborted_d;

  logic [LEN_WIDTH-1:0] words_inc;
  logic                 last_word;

  assign words_inc = words_q + LEN_WIDTH'(1);
  // The word being written in this cycle is the final one.
  assign last_word = (words_inc == len_q);

  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    dst_d     = dst_q;
    pattern_d = pattern_q;
    len_d     = len_q;
    words_d   = words_q;
    aborted_d = aborted_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          src_d     = {src_addr[31:2], 2'b00};
          dst_d     = {dst_addr[31:2], 2'b00};
          pattern_d = pattern;
          len_d     = len;
          words_d   = '0;
          aborted_d = 1'b0;
          if (len == '0) begin
            state_d = StFin;
          end else if (mode) begin
            state_d = StFill;
          end else begin
            state_d = StRd;
          end
        end
      end
      StRd: begin
        // An abort here drops the outstanding read; no write follows.
        if (abort) begin
          aborted_d = 1'b1;
          state_d   = StFin;
        end else begin
          state_d = StWr;
        end
      end
      StWr, StFill: begin
        // The write issued this cycle always completes and is counted.
        words_d = words_inc;
        dst_d   = dst_q + 32'd4;
        if (state_q == StWr) begin
          src_d = src_q + 32'd4;
        end
        if (abort || last_word) begin
          aborted_d = abort;
          state_d   = StFin;
        end else begin
          state_d = (state_q == StWr) ? StRd : StFill;
        end
      end
      StFin: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      src_q     <= '0;
      dst_q     <= '0;
      pattern_q <= '0;
      len_q     <= '0;
      words_q   <= '0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      pattern_q <= pattern_d;
      len_q     <= len_d;
      words_q   <= words_d;
      aborted_q <= aborted_d;
    end
  end

  // Outputs decode directly from flopped state and pointers, so reset clears
  // them without waiting for a clock edge.
  always_comb begin
    busy       = 1'b0;
    done       = 1'b0;
    req        = 1'b0;
    we         = 1'b0;
    be         = 4'h0;
    addr       = 32'h0;
    wdata      = 32'h0;
    aborted    = aborted_q;
    words_done = words_q;
    unique case (state_q)
      StRd: begin
        busy = 1'b1;
        req  = 1'b1;
        addr = src_q;
      end
      StWr: begin
        busy  = 1'b1;
        req   = 1'b1;
        we    = 1'b1;
        be    = 4'hF;
        addr  = dst_q;
        wdata = rdata;
      end
      StFill: begin
        busy  = 1'b1;
        req   = 1'b1;
        we    = 1'b1;
        be    = 4'hF;
        addr  = dst_q;
        wdata = pattern_q;
      end
      StFin: begin
        done = 1'b1;
      end
      default: begin
        done = 1'b0;
      end
    endcase
  end

endmodule
